// File: rtl/cam_pkg.sv
// Shared CAM geometry and entry layout, also used by the downstream priority encoder.
package cam_pkg;
   localparam int CAM_ENTRIES = 32;
   localparam int CAM_IDX_W   = 5;
   localparam int CAM_KEY_W   = 16;

   // Entry layout at the default key width; mask is meaningful only in ternary builds.
   typedef struct packed {
      logic [CAM_KEY_W-1:0] key;
      logic [CAM_KEY_W-1:0] mask;
      logic                 valid;
   } cam_entry_t;
endpackage

// File: rtl/cam_entry.sv
// One CAM entry: key/valid storage (plus care mask when CAM_TERNARY_EN is defined)
// and the combinational match against the search key.
module cam_entry
   import cam_pkg::*;
#(
   parameter int KEY_W = CAM_KEY_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic             wr_valid,
   input  logic [KEY_W-1:0] wr_key,
`ifdef CAM_TERNARY_EN
   input  logic [KEY_W-1:0] wr_mask,
`endif
   input  logic             flush,
   input  logic [KEY_W-1:0] srch_key,
   output logic             match
);

   logic             valid;
   logic [KEY_W-1:0] key;
   logic [KEY_W-1:0] care;

   // Flush outranks a same-cycle write; invalidate leaves key/mask untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
         key   <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (wr_en) begin
         valid <= wr_valid;
         if (wr_valid) key <= wr_key;
      end
   end

`ifdef CAM_TERNARY_EN
   logic [KEY_W-1:0] mask;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                            mask <= '0;
      else if (!flush && wr_en && wr_valid) mask <= wr_mask;
   end

   assign care = mask;
`else
   assign care = '1;
`endif

   assign match = valid && (((key ^ srch_key) & care) == '0);

endmodule

// File: rtl/cam_match_array.sv
// 32-entry CAM producing registered match lines for the priority encoder, plus an
// enc_vld strobe aligned to the encoder output. Ternary compare under CAM_TERNARY_EN.
module cam_match_array
   import cam_pkg::*;
#(
   parameter int KEY_W   = CAM_KEY_W,
   parameter int ENC_LAT = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [CAM_IDX_W-1:0]   wr_addr,
   input  logic [KEY_W-1:0]       wr_key,
`ifdef CAM_TERNARY_EN
   input  logic [KEY_W-1:0]       wr_mask,
`endif
   input  logic                   wr_valid,
   input  logic                   flush,
   input  logic                   srch_en,
   input  logic [KEY_W-1:0]       srch_key,
   output logic [CAM_ENTRIES-1:0] ml,
   output logic                   ml_vld,
   output logic                   enc_vld
);

   logic [CAM_ENTRIES-1:0] match_vec;
   logic [ENC_LAT-1:0]     vld_pipe;

   for (genvar i = 0; i < CAM_ENTRIES; i++) begin : g_entry
      cam_entry #(.KEY_W(KEY_W)) u_entry (
         .clk      (clk),
         .reset    (reset),
         .wr_en    (wr_en && (wr_addr == CAM_IDX_W'(i))),
         .wr_valid (wr_valid),
         .wr_key   (wr_key),
`ifdef CAM_TERNARY_EN
         .wr_mask  (wr_mask),
`endif
         .flush    (flush),
         .srch_key (srch_key),
         .match    (match_vec[i])
      );
   end

   // Idle cycles drive zero so the encoder reports no hit for them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ml     <= '0;
         ml_vld <= 1'b0;
      end else begin
         ml     <= srch_en ? match_vec : '0;
         ml_vld <= srch_en;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= ml_vld;
         for (int k = 1; k < ENC_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
      end
   end

   assign enc_vld = vld_pipe[ENC_LAT-1];

endmodule

// File: tb/tb_cam_match_array.sv
// Directed bench for cam_match_array: per-cycle vector table plus hand-written
// sequences for enc_vld latency, mid-stream reset and (if enabled) ternary match.
module tb_cam_match_array;

   localparam int KEY_W   = 16;
   localparam int ENC_LAT = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              wr_en;
   logic [4:0]        wr_addr;
   logic [KEY_W-1:0]  wr_key;
   logic [KEY_W-1:0]  wr_mask;
   logic              wr_valid;
   logic              flush;
   logic              srch_en;
   logic [KEY_W-1:0]  srch_key;
   logic [31:0]       ml;
   logic              ml_vld;
   logic              enc_vld;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   cam_match_array #(.KEY_W(KEY_W), .ENC_LAT(ENC_LAT)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_key   (wr_key),
`ifdef CAM_TERNARY_EN
      .wr_mask  (wr_mask),
`endif
      .wr_valid (wr_valid),
      .flush    (flush),
      .srch_en  (srch_en),
      .srch_key (srch_key),
      .ml       (ml),
      .ml_vld   (ml_vld),
      .enc_vld  (enc_vld)
   );

   typedef struct packed {
      logic             wr_en;
      logic [4:0]       wr_addr;
      logic [KEY_W-1:0] wr_key;
      logic             wr_valid;
      logic             flush;
      logic             srch_en;
      logic [KEY_W-1:0] srch_key;
      logic [31:0]      exp_ml;
      logic             exp_vld;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic we, logic [4:0] a, logic [KEY_W-1:0] k, logic wv,
                               logic fl, logic se, logic [KEY_W-1:0] sk,
                               logic [31:0] eml, logic ev);
      vec_t v;
      v.wr_en = we; v.wr_addr = a; v.wr_key = k; v.wr_valid = wv; v.flush = fl;
      v.srch_en = se; v.srch_key = sk; v.exp_ml = eml; v.exp_vld = ev;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic drive(input vec_t v);
      wr_en = v.wr_en; wr_addr = v.wr_addr; wr_key = v.wr_key; wr_valid = v.wr_valid;
      flush = v.flush; srch_en = v.srch_en; srch_key = v.srch_key;
   endtask

   task automatic idle();
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   // Drive one cycle of inputs at negedge, then land 1 time unit after the posedge.
   task automatic step(input vec_t v);
      @(negedge clk);
      drive(v);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      wr_mask = '1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      check("reset_ml", ml, 32'h0);
      check("reset_ml_vld", {31'b0, ml_vld}, 32'h0);
      check("reset_enc_vld", {31'b0, enc_vld}, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      //        we  addr key       wv fl se skey       exp_ml        ev
      vecs.push_back(mk(1,  5, 16'h1234, 1, 0, 0, 16'h0000, 32'h0000_0000, 0));
      vecs.push_back(mk(0,  0, 16'h0000, 0, 0, 1, 16'h1234, 32'h0000_0020, 1));
      vecs.push_back(mk(1,  3, 16'hBEEF, 1, 0, 0, 16'h0000, 32'h0000_0000, 0));
      vecs.push_back(mk(1, 17, 16'hBEEF, 1, 0, 1, 16'hBEEF, 32'h0000_0008, 1));
      vecs.push_back(mk(0,  0, 16'h0000, 0, 0, 1, 16'hBEEF, 32'h0002_0008, 1));
      vecs.push_back(mk(0,  0, 16'h0000, 0, 0, 1, 16'hBEEE, 32'h0000_0000, 1));
      vecs.push_back(mk(0,  0, 16'h0000, 0, 0, 0, 16'hBEEF, 32'h0000_0000, 0));
      vecs.push_back(mk(1,  3, 16'h0000, 0, 0, 1, 16'hBEEF, 32'h0002_0008, 1));
      vecs.push_back(mk(0,  0, 16'h0000, 0, 0, 1, 16'hBEEF, 32'h0002_0000, 1));
      vecs.push_back(mk(1,  7, 16'hAAAA, 1, 0, 1, 16'hAAAA, 32'h0000_0000, 1));
      vecs.push_back(mk(0,  0, 16'h0000, 0, 0, 1, 16'hAAAA, 32'h0000_0080, 1));
      vecs.push_back(mk(1,  3, 16'h1111, 1, 0, 1, 16'h1234, 32'h0000_0020, 1));
      vecs.push_back(mk(1,  9, 16'h5555, 1, 1, 1, 16'hAAAA, 32'h0000_0080, 1));
      vecs.push_back(mk(0,  0, 16'h0000, 0, 0, 1, 16'h5555, 32'h0000_0000, 1));
      vecs.push_back(mk(0,  0, 16'h0000, 0, 0, 1, 16'hAAAA, 32'h0000_0000, 1));
      vecs.push_back(mk(0,  0, 16'h0000, 0, 0, 1, 16'h1111, 32'h0000_0000, 1));
      vecs.push_back(mk(1,  9, 16'h5555, 1, 0, 0, 16'h0000, 32'h0000_0000, 0));
      vecs.push_back(mk(0,  0, 16'h0000, 0, 0, 1, 16'h5555, 32'h0000_0200, 1));
      vecs.push_back(mk(1,  5, 16'h4321, 1, 0, 1, 16'h5555, 32'h0000_0200, 1));
      vecs.push_back(mk(0,  0, 16'h0000, 0, 0, 1, 16'h1234, 32'h0000_0000, 1));
      vecs.push_back(mk(0,  0, 16'h0000, 0, 0, 1, 16'h4321, 32'h0000_0020, 1));
      vecs.push_back(mk(0,  0, 16'h0000, 0, 0, 1, 16'h0000, 32'h0000_0000, 1));
      vecs.push_back(mk(1, 31, 16'hFFFF, 1, 0, 0, 16'h0000, 32'h0000_0000, 0));
      vecs.push_back(mk(1,  0, 16'hFFFF, 1, 0, 1, 16'hFFFF, 32'h8000_0000, 1));
      vecs.push_back(mk(0,  0, 16'h0000, 0, 0, 1, 16'hFFFF, 32'h8000_0001, 1));
      vecs.push_back(mk(1,  0, 16'h0000, 0, 0, 1, 16'hFFFF, 32'h8000_0001, 1));
      vecs.push_back(mk(0,  0, 16'h0000, 0, 0, 1, 16'hFFFF, 32'h8000_0000, 1));

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i]);
         check($sformatf("vec%0d_ml", i), ml, vecs[i].exp_ml);
         check($sformatf("vec%0d_ml_vld", i), {31'b0, ml_vld}, {31'b0, vecs[i].exp_vld});
      end

      // enc_vld: single search, strobe exactly ENC_LAT edges after ml_vld.
      repeat (ENC_LAT + 2) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      check("drain_enc_vld", {31'b0, enc_vld}, 32'h0);
      step(mk(0, 0, 0, 0, 0, 1, 16'hFFFF, 0, 0));
      check("lat_ml", ml, 32'h8000_0000);
      check("lat_ml_vld", {31'b0, ml_vld}, 32'h1);
      check("lat_k0_enc_vld", {31'b0, enc_vld}, 32'h0);
      for (int k = 1; k <= ENC_LAT + 2; k++) begin
         step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
         check($sformatf("lat_k%0d_enc_vld", k), {31'b0, enc_vld}, {31'b0, (k == ENC_LAT)});
      end

      // Mid-stream reset with results in flight.
      for (int k = 0; k <= ENC_LAT; k++) step(mk(0, 0, 0, 0, 0, 1, 16'hFFFF, 0, 0));
      check("pre_rst_ml", ml, 32'h8000_0000);
      check("pre_rst_enc_vld", {31'b0, enc_vld}, 32'h1);
      srch_en = 1'b0;
      #1 reset = 1'b1;
      #1;
      check("rst_ml", ml, 32'h0);
      check("rst_ml_vld", {31'b0, ml_vld}, 32'h0);
      check("rst_enc_vld", {31'b0, enc_vld}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < ENC_LAT + 4; k++) begin
         step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
         check($sformatf("post_rst%0d_enc_vld", k), {31'b0, enc_vld}, 32'h0);
      end
      step(mk(0, 0, 0, 0, 0, 1, 16'hFFFF, 0, 0));
      check("post_rst_srch_ml", ml, 32'h0);
      check("post_rst_srch_ml_vld", {31'b0, ml_vld}, 32'h1);

`ifdef CAM_TERNARY_EN
      wr_mask = 16'hFF00;
      step(mk(1, 0, 16'h12FF, 1, 0, 0, 0, 0, 0));
      wr_mask = 16'hFFFF;
      step(mk(0, 0, 0, 0, 0, 1, 16'h1200, 0, 0));
      check("tern_1200_ml", ml, 32'h0000_0001);
      step(mk(0, 0, 0, 0, 0, 1, 16'h12AB, 0, 0));
      check("tern_12ab_ml", ml, 32'h0000_0001);
      step(mk(0, 0, 0, 0, 0, 1, 16'h1300, 0, 0));
      check("tern_1300_ml", ml, 32'h0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
